imem_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the single-cycle RISC-V core's instruction memory.
- Receives a byte stream over a valid/ready interface, for example from a UART receiver.
- Assembles little-endian 32-bit words and writes them sequentially into IMEM through a write port.
- Holds the core in reset until the image is fully loaded, then releases it.

---
 rtl/imem_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words for IMEM and holds the core in reset until done.
// Optional trailing-checksum verification is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t state, next_state;

    logic [1:0]      byte_cnt;
    logic [23:0]     shift;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] idx_next;
    logic [31:0]     word_in;
    logic [31:0]     addr_word;
    logic            accept;
    logic            last_byte;
    logic            leaving_end;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]     acc;
`endif

    // The byte being accepted completes the word on top of the three buffered bytes.
    assign word_in     = {byte_data, shift};
    assign byte_ready  = rst_n && (state == HDR || state == DATA
`ifdef IMEM_LOADER_CHECKSUM_EN
                                   || state == CSUM
`endif
                                  );
    assign accept      = byte_valid && byte_ready;
    assign last_byte   = accept && (byte_cnt == 2'd3);
    assign idx_next    = word_idx + 1'b1;
    assign addr_word   = {{(30 - ADDR_W){1'b0}}, word_idx[ADDR_W-1:0], 2'b00};
    assign imem_we     = (state == WRITE);
    assign leaving_end = reload && (state == DONE || state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HDR: begin
                if (last_byte) begin
                    if (word_in > DEPTH) begin
                        next_state = ERR;
                    end else if (word_in == '0) begin
                        next_state = AFTER_DATA;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = (idx_next == word_cnt) ? AFTER_DATA : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (last_byte) begin
                    next_state = (word_in == acc) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (reload) begin
                    next_state = HDR;
                end
            end
            default: next_state = HDR;
        endcase
    end

    // Status outputs are registered from the next state so they change on the entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            shift      <= '0;
            word_cnt   <= '0;
            word_idx   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done       <= (next_state == DONE);
            core_rst_n <= (next_state == DONE);
            err        <= (next_state == ERR);

            if (next_state != state) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (accept) begin
                shift <= word_in[31:8];
            end

            if (state == HDR && last_byte) begin
                word_cnt <= word_in[ADDR_W:0];
                word_idx <= '0;
            end

            if (state == DATA && last_byte) begin
                imem_addr  <= addr_word;
                imem_wdata <= word_in;
            end

            if (state == WRITE) begin
                word_idx <= idx_next;
            end

            if (leaving_end) begin
                word_idx <= '0;
                word_cnt <= '0;
                shift    <= '0;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running sum of every word written, restarted whenever a new image begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (next_state == HDR) begin
            acc <= '0;
        end else if (state == WRITE) begin
            acc <= acc + imem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic load, gaps, size boundaries, reload, async reset.
// Checksum vectors are added when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int ready_viol = 0;
    bit mon_en = 1'b0;
    bit stuck = 1'b0;
    logic [63:0] wlog[$];

    imem_loader #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every IMEM write and flag any cycle where byte_ready is not the inverse of imem_we while loading.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wlog.push_back({imem_addr, imem_wdata});
        end
        if (mon_en && (byte_ready === imem_we)) begin
            ready_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (stuck) return;
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_data  = b;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check_bit("accept_timeout", byte_ready, 1'b1);
            stuck = 1'b1;
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        check_bit("reload_core_rst", core_rst_n, 1'b0);
        check_bit("reload_done_clr", done, 1'b0);
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] sum;
        int bad;

        rst_n = 1'b0;
        byte_data = 8'h00;
        byte_valid = 1'b0;
        reload = 1'b0;

        // Reset values
        @(negedge clk);
        check_bit("rst_ready", byte_ready, 1'b0);
        check_bit("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check_bit("rst_core", core_rst_n, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("hdr_ready", byte_ready, 1'b1);

        // Basic load, valid held high including through WRITE cycles
        wlog.delete();
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        byte_valid = 1'b0;
        check_bit("basic_we", imem_we, 1'b1);
        check("basic_addr1", imem_addr, 32'h4);
        check("basic_wdata1", imem_wdata, 32'hDEAD_BEEF);
        check_bit("basic_ready_write", byte_ready, 1'b0);
        check_bit("basic_done_early", done, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDEAD_BF02, 1'b0);
        byte_valid = 1'b0;
`endif
        @(negedge clk);
        check_bit("basic_done", done, 1'b1);
        check_bit("basic_core", core_rst_n, 1'b1);
        check_bit("basic_we_off", imem_we, 1'b0);
        check_bit("basic_ready_done", byte_ready, 1'b0);
        check("basic_addr_hold", imem_addr, 32'h4);
        check("basic_nwrites", 32'(wlog.size()), 32'd2);
        check("basic_log0", wlog[0][63:32] ^ wlog[0][31:0], 32'h0000_0013);
        check("basic_log1", wlog[1][31:0], 32'hDEAD_BEEF);

        // Reload from DONE; a reload pulse mid-DATA must be ignored
        pulse_reload();
        wlog.delete();
        send_word(32'd1, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        reload = 1'b1;
        send_byte(8'h34, 1'b0);
        reload = 1'b0;
        send_byte(8'h12, 1'b0);
        byte_valid = 1'b0;
        check_bit("reld_we", imem_we, 1'b1);
        check("reld_addr", imem_addr, 32'h0);
        check("reld_wdata", imem_wdata, 32'h1234_5678);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h1234_5678, 1'b0);
        byte_valid = 1'b0;
`endif
        @(negedge clk);
        check_bit("reld_done", done, 1'b1);
        check_bit("reld_core", core_rst_n, 1'b1);
        check("reld_nwrites", 32'(wlog.size()), 32'd1);

        // Gapped stream: byte_ready must be low exactly in WRITE cycles
        pulse_reload();
        wlog.delete();
        ready_viol = 0;
        mon_en = 1'b1;
        send_word(32'd2, 1'b1);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1);
        byte_valid = 1'b0;
        mon_en = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDEAD_BF02, 1'b1);
        byte_valid = 1'b0;
`endif
        @(negedge clk);
        check_bit("gap_done", done, 1'b1);
        check("gap_ready_viol", 32'(ready_viol), 32'd0);
        check("gap_nwrites", 32'(wlog.size()), 32'd2);
        check("gap_log0", wlog[0][31:0], 32'h0000_0013);
        check("gap_log1_addr", wlog[1][63:32], 32'h4);
        check("gap_log1", wlog[1][31:0], 32'hDEAD_BEEF);

        // N = 0
        pulse_reload();
        wlog.delete();
        send_word(32'd0, 1'b0);
        byte_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
        byte_valid = 1'b0;
`endif
        check_bit("n0_done", done, 1'b1);
        check_bit("n0_core", core_rst_n, 1'b1);
        check("n0_nwrites", 32'(wlog.size()), 32'd0);

        // N = DEPTH + 1 is rejected right after the header
        pulse_reload();
        wlog.delete();
        send_word(32'd1025, 1'b0);
        byte_valid = 1'b0;
        check_bit("ovf_err", err, 1'b1);
        check_bit("ovf_core", core_rst_n, 1'b0);
        check_bit("ovf_done", done, 1'b0);
        check_bit("ovf_ready", byte_ready, 1'b0);
        byte_data = 8'hAA;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        check_bit("ovf_err_hold", err, 1'b1);
        check("ovf_nwrites", 32'(wlog.size()), 32'd0);

        // N = DEPTH fills IMEM exactly
        pulse_reload();
        wlog.delete();
        sum = 32'h0;
        send_word(32'd1024, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            send_word(32'hA500_0000 ^ 32'(i), 1'b0);
            sum = sum + (32'hA500_0000 ^ 32'(i));
        end
        byte_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum, 1'b0);
        byte_valid = 1'b0;
`endif
        @(negedge clk);
        check_bit("full_done", done, 1'b1);
        check("full_nwrites", 32'(wlog.size()), 32'd1024);
        check("full_last_addr", wlog[1023][63:32], 32'h0000_0FFC);
        check("full_last_data", wlog[1023][31:0], 32'hA500_03FF);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i] !== {32'(i * 4), 32'hA500_0000 ^ 32'(i)}) bad++;
        end
        check("full_bad_entries", 32'(bad), 32'd0);

        // Asynchronous reset midway through the second word
        pulse_reload();
        wlog.delete();
        send_word(32'd2, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        byte_valid = 1'b0;
        check("arst_pre_wdata", imem_wdata, 32'hCAFE_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("arst_ready", byte_ready, 1'b0);
        check("arst_wdata", imem_wdata, 32'h0);
        check_bit("arst_core", core_rst_n, 1'b0);
        check_bit("arst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("arst_ready_rel", byte_ready, 1'b1);
        send_word(32'd1, 1'b0);
        send_word(32'h0BAD_C0DE, 1'b0);
        byte_valid = 1'b0;
        check("arst_new_addr", imem_addr, 32'h0);
        check("arst_new_wdata", imem_wdata, 32'h0BAD_C0DE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0BAD_C0DE, 1'b0);
        byte_valid = 1'b0;
`endif
        @(negedge clk);
        check_bit("arst_new_done", done, 1'b1);
        check("arst_nwrites", 32'(wlog.size()), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_reload();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        byte_valid = 1'b0;
        check_bit("csum_ok_done", done, 1'b1);
        check_bit("csum_ok_err", err, 1'b0);
        pulse_reload();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        byte_valid = 1'b0;
        check_bit("csum_bad_err", err, 1'b1);
        check_bit("csum_bad_done", done, 1'b0);
        check_bit("csum_bad_core", core_rst_n, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
